myfifo_global_poly_input: RTL and testbench
===========================================

MYFIFO_GLOBAL_POLY_INPUT -- requirements
Module: myfifo_global_poly_input

Interface
REQ-001 SHALL have parameter POINTER_WIDTH, default 2, slot pointer width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2**POINTER_WIDTH, number of poly slots.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port empty, input→output, 1, no complete poly held (to top ctrl).
REQ-006 SHALL have port full, output, 1, all FIFO_DEPTH slots hold complete polys (to top ctrl).
REQ-007 SHALL have port outer_wr_finish, input, 1, low while the AXI DMA side writes a poly; high marks the end of the poly.
REQ-008 SHALL have port outer_wr_en, input, 1, write strobe for the current line.
REQ-009 SHALL have ports outer_wr_addrA and outer_wr_addrB, input, `ADDR_WIDTH, line addresses of the write slot.
REQ-010 SHALL have ports outer_wr_dA and outer_wr_dB, input, `BIT_WIDTH*`LINE_SIZE, write data.
REQ-011 SHALL have port outer_wr_full, output, 1, copy of full.
REQ-012 SHALL have port internal_rd_finish, input, 1, low while the CL consumes a poly; high marks the end of consumption.
REQ-013 SHALL have ports internal_rd_addrA and internal_rd_addrB, input, `ADDR_WIDTH, read line addresses.
REQ-014 SHALL have ports internal_rd_dA and internal_rd_dB, output, `BIT_WIDTH*`LINE_SIZE, read data.
REQ-015 SHALL have port internal_rd_empty, output, 1, copy of empty.

Function
REQ-016 SHALL keep wr_pointer and rd_pointer at POINTER_WIDTH+1 bits. full = low bits equal and MSBs differ; empty = all bits equal.
REQ-017 SHALL run the write FSM {WRIDLE, WR}.
  - WRIDLE→WR when outer_wr_finish=0.
  - WR→WRIDLE when outer_wr_finish=1, and wr_pointer+1 in the same cycle if !full.
  - The pointer wraps modulo 2**(POINTER_WIDTH+1).
REQ-018 SHALL run the read FSM {RDIDLE, RD} on internal_rd_finish in the same way.
  - RD→RDIDLE advances rd_pointer if !empty.
REQ-019 SHALL write dA to addrA and dB to addrB of slot wr_pointer[POINTER_WIDTH-1:0] when outer_wr_en=1, outer_wr_finish=0 and full=0. Otherwise no slot is written.
REQ-020 SHALL register read data of slot rd_pointer[POINTER_WIDTH-1:0] at internal_rd_addrA/B and present it on internal_rd_dA/dB one cycle after the address.
REQ-021 SHALL drive internal_rd_dA/dB to 0 on the cycle after an address presented while empty=1.
REQ-022 SHALL let the write and read FSMs advance in the same cycle independently. empty and full reflect both updates on the next cycle.
REQ-023 SHALL ignore writes while full=1; the slot under read is never overwritten.
REQ-024 SHALL return a line written to the slot being filled only after that slot's wr_finish advance. A read of a slot that is not yet complete is not possible, because empty stays asserted.
REQ-025 SHALL keep each slot's contents across reset; only pointers and FSMs reset.

Reset
REQ-026 SHALL on rst=1 set wr_pointer=0, rd_pointer=0, both FSMs to idle, internal_rd_dA/dB=0, empty=1, full=0.
REQ-027 SHALL abort, on reset mid-poly, any partially written or partially read poly. No pointer advance is recorded.

Configuration
REQ-028 SHALL, with macro GLOBAL_POLY_INPUT_COUNT_EN defined, add output count (POINTER_WIDTH+1 bits) = wr_pointer-rd_pointer, registered with the pointers, and 0 in reset.
REQ-029 SHALL, without GLOBAL_POLY_INPUT_COUNT_EN, omit the count port and its logic. All other behaviour is identical.

Verification (POINTER_WIDTH=2)
REQ-030 SHALL cover a single poly: reset, finish=0, write lines 0..3 with A=addr, B=addr+100, finish=1. Expect empty=0 next cycle; reading addr 2 returns A=2, B=102 one cycle later.
REQ-031 SHALL cover fill: 4 complete polys, then full=1 with count=4. A 5th poly with wr_en=1 leaves slot 0 contents unchanged.
REQ-032 SHALL cover simultaneous advance: with count=2, finish a write and a read in the same cycle. Expect count=2, full=0, empty=0 after.
REQ-033 SHALL cover wrap: 9 poly write/read pairs. After them, pointers are 1 (mod 8), empty=1, and every read matches data written to the same slot.
REQ-034 SHALL cover reset mid-write: 2 lines of a poly written, rst=1 for 1 cycle. Expect empty=1, full=0, internal_rd_dA=0, count=0.
REQ-035 SHALL cover read when empty: reset, then present read addr 5. Expect internal_rd_dA/dB=0 and rd_pointer unchanged after a finish pulse.

Source files
------------

// File: rtl/myfifo_global_poly_input.sv
// Poly-slot FIFO between the AXI DMA writer and the compute logic reader.
// Each slot holds one complete poly in two line banks (A and B). A slot is
// published to the reader only when the writer closes it with outer_wr_finish.
// Optional feature: define GLOBAL_POLY_INPUT_COUNT_EN to add the `count` output.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 2
`endif

module myfifo_global_poly_input #(
  parameter int POINTER_WIDTH = 2,
  parameter int FIFO_DEPTH    = 2**POINTER_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               empty,
  output logic                               full,
  input  logic                               outer_wr_finish,
  input  logic                               outer_wr_en,
  input  logic [`ADDR_WIDTH-1:0]             outer_wr_addrA,
  input  logic [`ADDR_WIDTH-1:0]             outer_wr_addrB,
  input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]   outer_wr_dA,
  input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]   outer_wr_dB,
  output logic                               outer_wr_full,
  input  logic                               internal_rd_finish,
  input  logic [`ADDR_WIDTH-1:0]             internal_rd_addrA,
  input  logic [`ADDR_WIDTH-1:0]             internal_rd_addrB,
  output logic [`BIT_WIDTH*`LINE_SIZE-1:0]   internal_rd_dA,
  output logic [`BIT_WIDTH*`LINE_SIZE-1:0]   internal_rd_dB,
  output logic                               internal_rd_empty
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
  ,
  output logic [POINTER_WIDTH:0]             count
`endif
);

  localparam int DW    = `BIT_WIDTH*`LINE_SIZE;
  localparam int LINES = 2**`ADDR_WIDTH;

  typedef enum logic {WRIDLE = 1'b0, WR = 1'b1} wr_state_e;
  typedef enum logic {RDIDLE = 1'b0, RD = 1'b1} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [POINTER_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                   wr_adv, rd_adv;
  logic                   mem_we;

  logic [DW-1:0] mem_a_q [FIFO_DEPTH][LINES];
  logic [DW-1:0] mem_b_q [FIFO_DEPTH][LINES];
  logic [DW-1:0] rd_da_q, rd_db_q;

  // Extra MSB on each pointer distinguishes a full ring from an empty one.
  assign full  = (wr_ptr_q[POINTER_WIDTH-1:0] == rd_ptr_q[POINTER_WIDTH-1:0]) &&
                 (wr_ptr_q[POINTER_WIDTH] != rd_ptr_q[POINTER_WIDTH]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign outer_wr_full     = full;
  assign internal_rd_empty = empty;
  assign internal_rd_dA    = rd_da_q;
  assign internal_rd_dB    = rd_db_q;

  // State registers for both FSMs; a reset mid-poly simply drops back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WRIDLE;
      rd_state_q <= RDIDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Write FSM next state: a poly opens on finish low and closes on finish high.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WRIDLE:  if (!outer_wr_finish) wr_state_d = WR;
      WR:      if (outer_wr_finish)  wr_state_d = WRIDLE;
      default: wr_state_d = WRIDLE;
    endcase
  end

  // Read FSM next state: mirrors the write FSM on internal_rd_finish.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RDIDLE:  if (!internal_rd_finish) rd_state_d = RD;
      RD:      if (internal_rd_finish)  rd_state_d = RDIDLE;
      default: rd_state_d = RDIDLE;
    endcase
  end

  // FSM outputs: closing a poly publishes (or releases) a slot unless blocked.
  always_comb begin
    wr_adv = (wr_state_q == WR) && outer_wr_finish && !full;
    rd_adv = (rd_state_q == RD) && internal_rd_finish && !empty;
    mem_we = outer_wr_en && !outer_wr_finish && !full && !rst;
  end

  // Pointer next values; both may step in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{POINTER_WIDTH{1'b0}}, wr_adv};
    rd_ptr_d = rd_ptr_q + {{POINTER_WIDTH{1'b0}}, rd_adv};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Slot storage has no reset so buffered polys survive a controller reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_a_q[wr_ptr_q[POINTER_WIDTH-1:0]][outer_wr_addrA] <= outer_wr_dA;
      mem_b_q[wr_ptr_q[POINTER_WIDTH-1:0]][outer_wr_addrB] <= outer_wr_dB;
    end
  end

  // Registered read of the head slot; returns zero while nothing is published.
  always_ff @(posedge clk) begin
    if (rst || empty) begin
      rd_da_q <= '0;
      rd_db_q <= '0;
    end else begin
      rd_da_q <= mem_a_q[rd_ptr_q[POINTER_WIDTH-1:0]][internal_rd_addrA];
      rd_db_q <= mem_b_q[rd_ptr_q[POINTER_WIDTH-1:0]][internal_rd_addrB];
    end
  end

`ifdef GLOBAL_POLY_INPUT_COUNT_EN
  logic [POINTER_WIDTH:0] count_q;

  // Occupancy tracked alongside the pointers so it lines up with full/empty.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= wr_ptr_d - rd_ptr_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_myfifo_global_poly_input.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 2
`endif

module tb_myfifo_global_poly_input;

  localparam int PW = 2;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `BIT_WIDTH*`LINE_SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty, full;
  logic          outer_wr_finish, outer_wr_en;
  logic [AW-1:0] outer_wr_addrA, outer_wr_addrB;
  logic [DW-1:0] outer_wr_dA, outer_wr_dB;
  logic          outer_wr_full;
  logic          internal_rd_finish;
  logic [AW-1:0] internal_rd_addrA, internal_rd_addrB;
  logic [DW-1:0] internal_rd_dA, internal_rd_dB;
  logic          internal_rd_empty;
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
  logic [PW:0]   count;
`endif

  int checks = 0;
  int errors = 0;

  myfifo_global_poly_input #(.POINTER_WIDTH(PW)) dut (
    .clk                (clk),
    .rst                (rst),
    .empty              (empty),
    .full               (full),
    .outer_wr_finish    (outer_wr_finish),
    .outer_wr_en        (outer_wr_en),
    .outer_wr_addrA     (outer_wr_addrA),
    .outer_wr_addrB     (outer_wr_addrB),
    .outer_wr_dA        (outer_wr_dA),
    .outer_wr_dB        (outer_wr_dB),
    .outer_wr_full      (outer_wr_full),
    .internal_rd_finish (internal_rd_finish),
    .internal_rd_addrA  (internal_rd_addrA),
    .internal_rd_addrB  (internal_rd_addrB),
    .internal_rd_dA     (internal_rd_dA),
    .internal_rd_dB     (internal_rd_dB),
    .internal_rd_empty  (internal_rd_empty)
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    ,
    .count              (count)
`endif
  );

  always #5 clk = ~clk;

  // Line contents for poly p: poly 0 gives A=line, B=line+100.
  function automatic logic [DW-1:0] dat_a(input int p, input int i);
    return DW'((p << 8) + i);
  endfunction

  function automatic logic [DW-1:0] dat_b(input int p, input int i);
    return DW'((p << 8) + i + 100);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst                = 1'b0;
    outer_wr_finish    = 1'b1;
    outer_wr_en        = 1'b0;
    outer_wr_addrA     = '0;
    outer_wr_addrB     = '0;
    outer_wr_dA        = '0;
    outer_wr_dB        = '0;
    internal_rd_finish = 1'b1;
    internal_rd_addrA  = '0;
    internal_rd_addrB  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_lines(input int p, input int n);
    outer_wr_finish = 1'b0;
    outer_wr_en     = 1'b1;
    for (int i = 0; i < n; i++) begin
      outer_wr_addrA = AW'(i);
      outer_wr_addrB = AW'(i);
      outer_wr_dA    = dat_a(p, i);
      outer_wr_dB    = dat_b(p, i);
      tick();
    end
    outer_wr_en = 1'b0;
  endtask

  task automatic finish_write();
    outer_wr_en     = 1'b0;
    outer_wr_finish = 1'b1;
    tick();
  endtask

  task automatic write_poly(input int p, input int n);
    write_lines(p, n);
    finish_write();
  endtask

  task automatic read_line(input int i);
    internal_rd_finish = 1'b0;
    internal_rd_addrA  = AW'(i);
    internal_rd_addrB  = AW'(i);
    tick();
  endtask

  task automatic finish_read();
    internal_rd_finish = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (internal_rd_dA !== '0) begin errors++; $display("FAIL reset_dA: got %h want 0", internal_rd_dA); end
    checks++; if (internal_rd_dB !== '0) begin errors++; $display("FAIL reset_dB: got %h want 0", internal_rd_dB); end
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_poly();
    do_reset();
    write_lines(0, 4);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_open_empty: got %b want 1", empty); end
    finish_write();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", empty); end
    checks++; if (internal_rd_empty !== 1'b0) begin errors++; $display("FAIL single_rd_empty: got %b want 0", internal_rd_empty); end
    read_line(2);
    checks++; if (internal_rd_dA !== DW'(2)) begin errors++; $display("FAIL single_dA: got %0d want 2", internal_rd_dA); end
    checks++; if (internal_rd_dB !== DW'(102)) begin errors++; $display("FAIL single_dB: got %0d want 102", internal_rd_dB); end
    finish_read();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drained: got %b want 1", empty); end
  endtask

  task automatic test_fill_and_simultaneous();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      write_poly(10 + p, 4);
      if (p == 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_three_full: got %b want 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (outer_wr_full !== 1'b1) begin errors++; $display("FAIL fill_wr_full: got %b want 1", outer_wr_full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", empty); end
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
`endif
    write_poly(8'hEE, 4);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_fifth_full: got %b want 1", full); end
    read_line(1);
    checks++; if (internal_rd_dA !== dat_a(10, 1)) begin errors++; $display("FAIL fill_slot0_dA: got %h want %h", internal_rd_dA, dat_a(10, 1)); end
    checks++; if (internal_rd_dB !== dat_b(10, 1)) begin errors++; $display("FAIL fill_slot0_dB: got %h want %h", internal_rd_dB, dat_b(10, 1)); end
    finish_read();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_release_full: got %b want 0", full); end
    read_line(2);
    checks++; if (internal_rd_dA !== dat_a(11, 2)) begin errors++; $display("FAIL fill_slot1_dA: got %h want %h", internal_rd_dA, dat_a(11, 2)); end
    finish_read();
    // Two polys held (slots 2,3); write slot 0 while consuming slot 2.
    outer_wr_finish    = 1'b0;
    outer_wr_en        = 1'b1;
    internal_rd_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      outer_wr_addrA    = AW'(i);
      outer_wr_addrB    = AW'(i);
      outer_wr_dA       = dat_a(20, i);
      outer_wr_dB       = dat_b(20, i);
      internal_rd_addrA = AW'(i);
      internal_rd_addrB = AW'(i);
      tick();
      checks++; if (internal_rd_dA !== dat_a(12, i)) begin errors++; $display("FAIL simul_dA line %0d: got %h want %h", i, internal_rd_dA, dat_a(12, i)); end
    end
    outer_wr_en        = 1'b0;
    outer_wr_finish    = 1'b1;
    internal_rd_finish = 1'b1;
    tick();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full: got %b want 0", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b want 0", empty); end
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", count); end
`endif
    read_line(0);
    checks++; if (internal_rd_dB !== dat_b(13, 0)) begin errors++; $display("FAIL drain_slot3_dB: got %h want %h", internal_rd_dB, dat_b(13, 0)); end
    finish_read();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL drain_one_left: got %b want 0", empty); end
    read_line(3);
    checks++; if (internal_rd_dA !== dat_a(20, 3)) begin errors++; $display("FAIL drain_slot0_dA: got %h want %h", internal_rd_dA, dat_a(20, 3)); end
    finish_read();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 9; p++) begin
      write_poly(40 + p, 4);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL wrap_pair%0d_empty: got %b want 0", p, empty); end
      for (int i = 0; i < 4; i++) begin
        read_line(i);
        checks++;
        if (internal_rd_dA !== dat_a(40 + p, i) || internal_rd_dB !== dat_b(40 + p, i)) begin
          errors++;
          $display("FAIL wrap_pair%0d_line%0d: got %h/%h want %h/%h", p, i,
                   internal_rd_dA, internal_rd_dB, dat_a(40 + p, i), dat_b(40 + p, i));
        end
      end
      finish_read();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b want 0", full); end
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_count: got %0d want 0", count); end
`endif
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    write_poly(60, 4);
    read_line(1);
    checks++; if (internal_rd_dA !== dat_a(60, 1)) begin errors++; $display("FAIL midrst_pre_dA: got %h want %h", internal_rd_dA, dat_a(60, 1)); end
    write_lines(61, 2);
    rst = 1'b1;
    tick();
    idle_inputs();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b want 0", full); end
    checks++; if (internal_rd_dA !== '0) begin errors++; $display("FAIL midrst_dA: got %h want 0", internal_rd_dA); end
`ifdef GLOBAL_POLY_INPUT_COUNT_EN
    checks++; if (count !== '0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
`endif
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_no_advance: got %b want 1", empty); end
  endtask

  task automatic test_read_empty();
    do_reset();
    write_poly(70, 6);
    do_reset();
    read_line(5);
    checks++; if (internal_rd_dA !== '0) begin errors++; $display("FAIL rdempty_dA: got %h want 0", internal_rd_dA); end
    checks++; if (internal_rd_dB !== '0) begin errors++; $display("FAIL rdempty_dB: got %h want 0", internal_rd_dB); end
    finish_read();
    write_lines(71, 4);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rdempty_partial: got %b want 1", empty); end
    finish_write();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rdempty_ptr_held: got %b want 0", empty); end
    read_line(2);
    checks++; if (internal_rd_dA !== dat_a(71, 2)) begin errors++; $display("FAIL rdempty_after_dA: got %h want %h", internal_rd_dA, dat_a(71, 2)); end
    finish_read();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_poly();
    test_fill_and_simultaneous();
    test_wrap();
    test_reset_mid_write();
    test_read_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
